debug_unit: RTL and testbench

Byte-command controller between a UART transceiver and the MIPS pipeline top. Loads the instruction memory from a host byte stream, holds the pipeline in reset during loading, runs or single-steps it via a clock enable, and reports PC and an executed-cycle count back over UART. It replaces the testbench-driven clock/reset sequencing with host-controlled bring-up on hardware.

---
 rtl/debug_unit.sv | 188 ++++++++++++++++++
 tb/tb_debug_unit.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: byte-command controller between a UART transceiver and the
// pipeline. The host loads instruction memory, runs the core until it halts
// or steps it one cycle at a time, and then reads back PC and the executed
// cycle count.
//
// Commands accepted in IDLE (all other bytes are ignored):
//   'L' (0x4C) : 16-bit little-endian word count N, then 4*N bytes, each word
//                little-endian. The core is held in reset while loading.
//   'R' (0x52) : run until halt, then report.
//   'S' (0x53) : step one cycle, then report.
// Report: 8 bytes, pc[7:0] .. pc[31:24], then cycle count in the same order.
//
// Ports:
//   clk, reset                   system clock, synchronous active-low reset
//   rx_data, rx_done             received byte and its one-cycle strobe
//   tx_data, tx_start, tx_done   byte to send, send request, send complete
//   imem_wr_en/addr/data         instruction-memory write port
//   cpu_reset, cpu_enable        pipeline reset (active high), clock enable
//   halt, pc                     pipeline status inputs
module debug_unit #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [LEN-1:0]        imem_wr_data,
    output logic                  cpu_reset,
    output logic                  cpu_enable,
    input  logic                  halt,
    input  logic [LEN-1:0]        pc
);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CNT_LO,
        LOAD_CNT_HI,
        LOAD_BYTE,
        WRITE,
        RUN,
        STEP,
        SEND,
        WAIT_TX
    } state_t;

    state_t      state;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;     // first three bytes of the word being received
    logic [31:0] cycle_count;
    logic [55:0] tx_shift;     // report bytes still to be sent, LSB first
    logic [2:0]  tx_idx;       // report bytes already acknowledged

    // Enable is combinational on halt so the core stops in the same cycle
    // halt rises; the counter therefore never counts a cycle the core skipped.
    assign cpu_enable = (state == STEP) || ((state == RUN) && !halt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_reset    <= 1'b1;
            word_count   <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            cycle_count  <= '0;
            tx_shift     <= '0;
            tx_idx       <= '0;
        end else begin
            tx_start   <= 1'b0;
            imem_wr_en <= 1'b0;
            if (cpu_enable) begin
                cycle_count <= cycle_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (rx_done) begin
                        case (rx_data)
                            CMD_LOAD: begin
                                cpu_reset   <= 1'b1;
                                cycle_count <= '0;
                                state       <= LOAD_CNT_LO;
                            end
                            CMD_RUN:  state <= halt ? SEND : RUN;
                            CMD_STEP: state <= halt ? SEND : STEP;
                            default:  state <= IDLE;
                        endcase
                    end
                end

                LOAD_CNT_LO: begin
                    if (rx_done) begin
                        word_count[7:0] <= rx_data;
                        state           <= LOAD_CNT_HI;
                    end
                end

                LOAD_CNT_HI: begin
                    if (rx_done) begin
                        word_count[15:8] <= rx_data;
                        word_idx         <= '0;
                        byte_idx         <= '0;
                        if ({rx_data, word_count[7:0]} == 16'd0) begin
                            cpu_reset <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= LOAD_BYTE;
                        end
                    end
                end

                LOAD_BYTE: begin
                    if (rx_done) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= word_idx[ADDR_WIDTH-1:0];
                            imem_wr_data <= LEN'({rx_data, word_buf});
                            state        <= WRITE;
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end
                end

                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == word_count) begin
                        cpu_reset <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end

                RUN: begin
                    if (halt) begin
                        state <= SEND;
                    end
                end

                STEP: state <= SEND;

                SEND: begin
                    // Core is stopped here, so pc and the counter are stable.
                    tx_data  <= pc[7:0];
                    tx_shift <= {cycle_count, pc[31:8]};
                    tx_idx   <= '0;
                    tx_start <= 1'b1;
                    state    <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (tx_done) begin
                        if (tx_idx == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            tx_data  <= tx_shift[7:0];
                            tx_shift <= {8'h00, tx_shift[55:8]};
                            tx_idx   <= tx_idx + 3'd1;
                            tx_start <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: directed scenarios followed by randomized loads and
// commands, checked against a behavioural model of the host protocol.
module tb_debug_unit;

    localparam int LEN = 32;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [LEN-1:0] imem_wr_data;
    logic          cpu_reset;
    logic          cpu_enable;
    logic          halt;
    logic [LEN-1:0] pc;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Activity counters sampled on the falling edge.
    int unsigned en_count = 0;
    int unsigned txs_count = 0;
    int unsigned wr_count = 0;

    // Model state: expected cycle counter and expected cpu_reset level.
    logic [31:0] exp_count;
    bit          exp_cpu_reset;
    logic [31:0] load_words[$];

    debug_unit #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .cpu_enable   (cpu_enable),
        .halt         (halt),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_enable === 1'b1) en_count++;
        if (tx_start === 1'b1) txs_count++;
        if (imem_wr_en === 1'b1) wr_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Acts as the UART transmitter: checks each byte, its tx_start timing and
    // that tx_data holds until tx_done.
    task automatic collect_report(input logic [31:0] exp_pc, input logic [31:0] exp_cnt,
                                  input bit stray_rx);
        logic [63:0] v;
        logic [7:0]  eb;
        int unsigned waited, hold, t0;
        bit          found, extra;
        @(posedge clk); #1;
        t0 = txs_count;
        v  = {exp_cnt, exp_pc};
        for (int unsigned i = 0; i < 8; i++) begin
            eb = v[8*i +: 8];
            found = 0;
            waited = 0;
            while (!found && waited < 20) begin
                @(negedge clk);
                if (tx_start === 1'b1) found = 1;
                else waited++;
            end
            vectors++;
            if (!found || (i > 0 && waited != 0)) begin
                miscompares++;
                $display("FAIL tx_start_timing byte %0d: found=%0d after %0d cycles, required prompt pulse", i, found, waited);
            end
            vectors++;
            if (tx_data !== eb) begin
                miscompares++;
                $display("FAIL tx_byte %0d: got %h expected %h", i, tx_data, eb);
            end
            hold = $urandom_range(4, 1);
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                vectors++;
                if (tx_start !== 1'b0 || tx_data !== eb) begin
                    miscompares++;
                    $display("FAIL tx_hold byte %0d: tx_start=%b tx_data=%h expected 0/%h", i, tx_start, tx_data, eb);
                end
                if (stray_rx && i == 5) begin
                    @(posedge clk); #1;
                    rx_data = 8'h4C; rx_done = 1'b1;
                    @(posedge clk); #1;
                    rx_done = 1'b0;
                end
            end
            @(posedge clk); #1;
            tx_done = 1'b1;
            if (stray_rx && i == 2) begin
                rx_data = 8'h4C; rx_done = 1'b1;
            end
            @(posedge clk); #1;
            tx_done = 1'b0;
            rx_done = 1'b0;
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_start === 1'b1) extra = 1;
        end
        vectors++;
        if (extra) begin
            miscompares++;
            $display("FAIL tx_extra: tx_start after 8th byte, expected none");
        end
        @(posedge clk); #1;
        vectors++;
        if (txs_count - t0 != 8) begin
            miscompares++;
            $display("FAIL tx_pulse_total: got %0d expected 8", txs_count - t0);
        end
        vectors++;
        if (cpu_reset !== exp_cpu_reset) begin
            miscompares++;
            $display("FAIL post_report_cpu_reset: got %b expected %b", cpu_reset, exp_cpu_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; halt = 1'b0; pc = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0 || tx_start !== 1'b0 || imem_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: cpu_reset=%b cpu_enable=%b tx_start=%b imem_wr_en=%b expected 1 0 0 0",
                     cpu_reset, cpu_enable, tx_start, imem_wr_en);
        end
        vectors++;
        if (tx_data !== 8'h00 || imem_wr_addr !== '0 || imem_wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: tx_data=%h addr=%h data=%h expected zeros", tx_data, imem_wr_addr, imem_wr_data);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_count = '0;
        exp_cpu_reset = 1;
        idle_cycles(2);
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: cpu_reset=%b cpu_enable=%b expected 1 0", cpu_reset, cpu_enable);
        end
    endtask

    task automatic test_load(input int unsigned n, input int unsigned gap_max);
        int unsigned w0;
        logic [31:0] w;
        logic [7:0]  b;
        logic [AW-1:0] ea;
        @(posedge clk); #1;
        w0 = wr_count;
        send_byte(8'h4C);
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL load_hold_reset: cpu_reset=%b expected 1", cpu_reset);
        end
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        exp_count = '0;
        if (n == 0) begin
            @(negedge clk);
            vectors++;
            if (cpu_reset !== 1'b0 || imem_wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL load_zero: cpu_reset=%b imem_wr_en=%b expected 0 0", cpu_reset, imem_wr_en);
            end
        end
        for (int unsigned i = 0; i < n; i++) begin
            w = load_words[i];
            for (int unsigned k = 0; k < 4; k++) begin
                idle_cycles($urandom_range(gap_max, 0));
                b = w[8*k +: 8];
                send_byte(b);
            end
            @(negedge clk);
            ea = AW'(i % (1 << AW));
            vectors++;
            if (imem_wr_en !== 1'b1 || imem_wr_addr !== ea || imem_wr_data !== w || cpu_reset !== 1'b1) begin
                miscompares++;
                $display("FAIL load_write word %0d: en=%b addr=%h data=%h rst=%b expected 1 %h %h 1",
                         i, imem_wr_en, imem_wr_addr, imem_wr_data, cpu_reset, ea, w);
            end
            if (i == n - 1) begin
                @(posedge clk);
                @(negedge clk);
                vectors++;
                if (cpu_reset !== 1'b0 || imem_wr_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_release: cpu_reset=%b imem_wr_en=%b expected 0 0", cpu_reset, imem_wr_en);
                end
            end
        end
        idle_cycles(2);
        vectors++;
        if (wr_count - w0 != n) begin
            miscompares++;
            $display("FAIL load_strobes: got %0d expected %0d", wr_count - w0, n);
        end
        exp_cpu_reset = 0;
    endtask

    task automatic test_step(input logic [31:0] pc_val, input bit halted);
        int unsigned e0;
        @(posedge clk); #1;
        pc = pc_val;
        halt = halted;
        e0 = en_count;
        send_byte(8'h53);
        if (!halted) begin
            @(negedge clk);
            vectors++;
            if (cpu_enable !== 1'b1) begin
                miscompares++;
                $display("FAIL step_enable: got %b expected 1", cpu_enable);
            end
            exp_count = exp_count + 32'd1;
        end
        @(negedge clk);
        vectors++;
        if (cpu_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL step_enable_low: got %b expected 0", cpu_enable);
        end
        collect_report(pc_val, exp_count, !exp_cpu_reset);
        vectors++;
        if (en_count - e0 != (halted ? 0 : 1)) begin
            miscompares++;
            $display("FAIL step_enable_total: got %0d expected %0d", en_count - e0, halted ? 0 : 1);
        end
    endtask

    task automatic test_run(input int unsigned k, input logic [31:0] pc_final, input bit halted);
        int unsigned e0;
        @(posedge clk); #1;
        halt = halted;
        pc = halted ? pc_final : $urandom;
        e0 = en_count;
        send_byte(8'h52);
        if (!halted) begin
            for (int unsigned j = 0; j < k; j++) begin
                @(negedge clk);
                vectors++;
                if (cpu_enable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL run_enable cycle %0d: got %b expected 1", j, cpu_enable);
                end
                @(posedge clk); #1;
                if (j == k - 1) begin
                    halt = 1'b1;
                    pc = pc_final;
                end else begin
                    pc = $urandom;
                end
            end
            exp_count = exp_count + k;
        end
        @(negedge clk);
        vectors++;
        if (cpu_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL run_halted_enable: got %b expected 0", cpu_enable);
        end
        collect_report(pc_final, exp_count, !exp_cpu_reset);
        vectors++;
        if (en_count - e0 != (halted ? 0 : k)) begin
            miscompares++;
            $display("FAIL run_enable_total: got %0d expected %0d", en_count - e0, halted ? 0 : k);
        end
    endtask

    task automatic test_ignore_byte();
        logic [7:0] b;
        int unsigned e0, t0, w0;
        do b = 8'($urandom_range(255, 0));
        while (b == 8'h4C || b == 8'h52 || b == 8'h53);
        @(posedge clk); #1;
        halt = 1'b0;
        e0 = en_count; t0 = txs_count; w0 = wr_count;
        send_byte(b);
        idle_cycles(4);
        vectors++;
        if (en_count != e0 || txs_count != t0 || wr_count != w0 || cpu_reset !== exp_cpu_reset) begin
            miscompares++;
            $display("FAIL ignore_byte %h: en+%0d tx+%0d wr+%0d cpu_reset=%b expected 0 0 0 %b",
                     b, en_count - e0, txs_count - t0, wr_count - w0, cpu_reset, exp_cpu_reset);
        end
    endtask

    task automatic test_abort_load();
        int unsigned w0;
        @(posedge clk); #1;
        w0 = wr_count;
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (cpu_reset !== 1'b1 || imem_wr_en !== 1'b0 || cpu_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_load_outputs: cpu_reset=%b wr_en=%b en=%b expected 1 0 0", cpu_reset, imem_wr_en, cpu_enable);
        end
        idle_cycles(2);
        reset = 1'b1;
        exp_count = '0;
        exp_cpu_reset = 1;
        send_byte(8'h33);
        send_byte(8'h44);
        idle_cycles(3);
        vectors++;
        if (wr_count != w0 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_load_write: strobes=%0d cpu_reset=%b expected 0 1", wr_count - w0, cpu_reset);
        end
    endtask

    task automatic test_abort_send();
        int unsigned t0, waited;
        bit found;
        @(posedge clk); #1;
        halt = 1'b1;
        pc = $urandom;
        t0 = txs_count;
        send_byte(8'h53);
        found = 0; waited = 0;
        while (!found && waited < 10) begin
            @(negedge clk);
            if (tx_start === 1'b1) found = 1;
            else waited++;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL abort_send_start: no tx_start within %0d cycles", waited);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_send_outputs: tx_start=%b tx_data=%h cpu_reset=%b expected 0 00 1", tx_start, tx_data, cpu_reset);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_count = '0;
        exp_cpu_reset = 1;
        repeat (2) begin
            @(posedge clk); #1; tx_done = 1'b1;
            @(posedge clk); #1; tx_done = 1'b0;
        end
        idle_cycles(4);
        vectors++;
        if (txs_count - t0 != 1) begin
            miscompares++;
            $display("FAIL abort_send_pulses: got %0d expected 1", txs_count - t0);
        end
    endtask

    task automatic test_random(input int unsigned iters);
        int unsigned n, op;
        for (int unsigned it = 0; it < iters; it++) begin
            n = $urandom_range(4, 1);
            load_words.delete();
            for (int unsigned i = 0; i < n; i++) load_words.push_back($urandom);
            test_load(n, 3);
            for (int unsigned o = 0; o < 4; o++) begin
                op = $urandom_range(3, 0);
                case (op)
                    0: test_step($urandom, 0);
                    1: test_run($urandom_range(20, 1), $urandom, 0);
                    2: if ($urandom_range(1, 0) == 1) test_run(0, $urandom, 1);
                       else test_step($urandom, 1);
                    default: test_ignore_byte();
                endcase
            end
        end
    endtask

    task automatic test_addr_wrap();
        load_words.delete();
        for (int unsigned i = 0; i < 1026; i++) load_words.push_back($urandom);
        test_load(1026, 0);
        test_step($urandom, 0);
    endtask

    initial begin
        test_reset();

        load_words.delete();
        load_words.push_back(32'h12345678);
        load_words.push_back(32'hDEADBEEF);
        test_load(2, 0);

        load_words.delete();
        test_load(0, 0);

        test_step(32'h0000_0004, 0);
        test_run(10, 32'h0000_0028, 0);
        test_run(0, $urandom, 1);
        test_step($urandom, 1);
        test_ignore_byte();

        test_abort_load();
        test_run(0, $urandom, 1);
        test_abort_send();
        test_step($urandom, 1);

        test_random(6);
        test_addr_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
